// File: rtl/noc_pkg.sv
// noc_pkg: shared widths, word type and per-word send-state encoding for the NoC injector.
package noc_pkg;
  localparam int ADDR_W = 4;
  localparam int DATA_W = 8;
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } ini_word_t;
  // Encoding is the {a_done, b_done} flag pair; 2'b11 is never stored.
  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    B_SENT = 2'b01,
    A_SENT = 2'b10
  } send_state_t;
endpackage

// File: rtl/ini_fifo.sv
// ini_fifo: synchronous FIFO with wrap-bit pointers and asynchronous active-low reset.
module ini_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 12
) (
  input  logic         CLK,
  input  logic         _RESET,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] head,
  output logic         empty,
  output logic         full
);
  localparam int AW = $clog2(DEPTH);
  logic [AW:0]  wptr, rptr;
  logic [W-1:0] mem [DEPTH];
  always_ff @(posedge CLK or negedge _RESET)
    if (!_RESET) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop) rptr <= rptr + 1'b1;
    end
  always_ff @(posedge CLK)
    if (push) mem[wptr[AW-1:0]] <= wdata;
  assign head  = mem[rptr[AW-1:0]];
  assign empty = wptr == rptr;
  assign full  = wptr[AW-1:0] == rptr[AW-1:0] && wptr[AW] != rptr[AW];
endmodule

// File: rtl/ini_injector.sv
// ini_injector: buffers PE words and issues each as independent A (address) and B (data) transfers.
module ini_injector #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = noc_pkg::ADDR_W,
  parameter int DATA_W = noc_pkg::DATA_W,
  parameter int CNT_W  = 8
) (
  input  logic              CLK,
  input  logic              _RESET,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [DATA_W-1:0] in_data,
  output logic              a_valid,
  input  logic              a_ready,
  output logic [ADDR_W-1:0] a_data,
  output logic              b_valid,
  input  logic              b_ready,
  output logic [DATA_W-1:0] b_data,
  output logic [CNT_W-1:0]  sent_cnt,
  output logic              empty,
  output logic              full
);
  import noc_pkg::*;
  send_state_t state, state_nx;
  logic a_hs, b_hs, pop;
  logic [ADDR_W+DATA_W-1:0] head;
  assign in_ready = !full && _RESET;
  ini_fifo #(.DEPTH(DEPTH), .W(ADDR_W + DATA_W)) u_fifo (
    .CLK    (CLK),
    ._RESET (_RESET),
    .push   (in_valid && in_ready),
    .pop    (pop),
    .wdata  ({in_addr, in_data}),
    .head   (head),
    .empty  (empty),
    .full   (full)
  );
  assign {a_data, b_data} = head;
  // A word retires once each half has been accepted, in this edge or an earlier one.
  always_comb begin
    a_valid  = !empty && state != A_SENT;
    b_valid  = !empty && state != B_SENT;
    a_hs     = a_valid && a_ready;
    b_hs     = b_valid && b_ready;
    pop      = !empty && (a_hs || state == A_SENT) && (b_hs || state == B_SENT);
    state_nx = pop ? IDLE : a_hs ? A_SENT : b_hs ? B_SENT : state;
  end
  always_ff @(posedge CLK or negedge _RESET)
    if (!_RESET) begin
      state    <= IDLE;
      sent_cnt <= '0;
    end else begin
      state <= state_nx;
      if (pop) sent_cnt <= sent_cnt + 1'b1;
    end
endmodule

// File: tb/tb_ini_injector.sv
// tb_ini_injector: table vectors, directed corner sequences and random traffic against a queue model.
module tb_ini_injector;
  import noc_pkg::*;
  localparam int DEPTH = 4;
  logic CLK = 0, _RESET = 0;
  logic in_valid = 0, a_ready = 0, b_ready = 0;
  logic [3:0] in_addr = 0;
  logic [7:0] in_data = 0;
  logic in_ready, a_valid, b_valid, empty, full;
  logic [3:0] a_data;
  logic [7:0] b_data, sent_cnt;
  int checks = 0, errors = 0;
  ini_word_t q[$];
  bit mad, mbd;
  int mcnt;

  ini_injector dut (
    .CLK(CLK), ._RESET(_RESET), .in_valid(in_valid), .in_ready(in_ready),
    .in_addr(in_addr), .in_data(in_data), .a_valid(a_valid), .a_ready(a_ready),
    .a_data(a_data), .b_valid(b_valid), .b_ready(b_ready), .b_data(b_data),
    .sent_cnt(sent_cnt), .empty(empty), .full(full)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, act, exp, $time);
    end
  endtask

  // One cycle: compare outputs with the model, drive inputs, advance model and clock.
  task automatic step(input bit iv, input logic [3:0] ad, input logic [7:0] dd,
                      input bit ar, input bit br, output bit acc);
    bit eav, ebv, ah, bh, fin;
    eav = q.size() > 0 && !mad;
    ebv = q.size() > 0 && !mbd;
    chk("in_ready", in_ready, q.size() < DEPTH);
    chk("a_valid", a_valid, eav);
    chk("b_valid", b_valid, ebv);
    chk("empty", empty, q.size() == 0);
    chk("full", full, q.size() == DEPTH);
    chk("sent_cnt", sent_cnt, mcnt % 256);
    if (eav) chk("a_data", a_data, q[0].addr);
    if (ebv) chk("b_data", b_data, q[0].data);
    in_valid = iv; in_addr = ad; in_data = dd; a_ready = ar; b_ready = br;
    acc = iv && q.size() < DEPTH;
    ah = eav && ar;
    bh = ebv && br;
    fin = q.size() > 0 && (mad || ah) && (mbd || bh);
    if (fin) begin
      void'(q.pop_front());
      mad = 0; mbd = 0; mcnt++;
    end else begin
      mad |= ah; mbd |= bh;
    end
    if (acc) q.push_back('{addr: ad, data: dd});
    @(posedge CLK);
    @(negedge CLK);
  endtask

  typedef struct {
    bit iv; logic [3:0] ad; logic [7:0] dd; bit ar, br;
    bit eav, ebv; logic [3:0] ea; logic [7:0] ed; int ecnt; bit eempty;
  } vec_t;
  vec_t tv[14];

  initial begin
    bit acc;
    int base, n;
    tv[0]  = '{1, 4'h5, 8'hA3, 1, 1, 0, 0, 4'h0, 8'h00, 0, 1};
    tv[1]  = '{0, 4'h0, 8'h00, 1, 1, 1, 1, 4'h5, 8'hA3, 0, 0};
    tv[2]  = '{0, 4'h0, 8'h00, 1, 1, 0, 0, 4'h0, 8'h00, 1, 1};
    tv[3]  = '{1, 4'h3, 8'h7E, 0, 0, 0, 0, 4'h0, 8'h00, 1, 1};
    tv[4]  = '{0, 4'h0, 8'h00, 0, 1, 1, 1, 4'h3, 8'h7E, 1, 0};
    tv[5]  = '{0, 4'h0, 8'h00, 0, 0, 1, 0, 4'h3, 8'h00, 1, 0};
    tv[6]  = '{0, 4'h0, 8'h00, 0, 1, 1, 0, 4'h3, 8'h00, 1, 0};
    tv[7]  = '{0, 4'h0, 8'h00, 1, 0, 1, 0, 4'h3, 8'h00, 1, 0};
    tv[8]  = '{1, 4'h9, 8'hC4, 0, 0, 0, 0, 4'h0, 8'h00, 2, 1};
    tv[9]  = '{0, 4'h0, 8'h00, 1, 0, 1, 1, 4'h9, 8'hC4, 2, 0};
    tv[10] = '{0, 4'h0, 8'h00, 1, 0, 0, 1, 4'h0, 8'hC4, 2, 0};
    tv[11] = '{0, 4'h0, 8'h00, 0, 0, 0, 1, 4'h0, 8'hC4, 2, 0};
    tv[12] = '{0, 4'h0, 8'h00, 0, 1, 0, 1, 4'h0, 8'hC4, 2, 0};
    tv[13] = '{0, 4'h0, 8'h00, 0, 0, 0, 0, 4'h0, 8'h00, 3, 1};
    // Reset state
    #1;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_a_valid", a_valid, 0);
    chk("rst_b_valid", b_valid, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_sent_cnt", sent_cnt, 0);
    repeat (2) @(posedge CLK);
    #2 _RESET = 1;
    @(negedge CLK);
    // Table: single word, B-then-A split, A-then-B split
    foreach (tv[i]) begin
      chk("tv_a_valid", a_valid, tv[i].eav);
      chk("tv_b_valid", b_valid, tv[i].ebv);
      if (tv[i].eav) chk("tv_a_data", a_data, tv[i].ea);
      if (tv[i].ebv) chk("tv_b_data", b_data, tv[i].ed);
      chk("tv_sent_cnt", sent_cnt, tv[i].ecnt);
      chk("tv_empty", empty, tv[i].eempty);
      step(tv[i].iv, tv[i].ad, tv[i].dd, tv[i].ar, tv[i].br, acc);
    end
    // Fill with readies low, fifth word held off until drain
    base = mcnt;
    for (int i = 0; i < 4; i++) step(1, 4'(i), 8'h40 + 8'(i), 0, 0, acc);
    chk("fill_full", full, 1);
    chk("fill_in_ready", in_ready, 0);
    step(1, 4'h4, 8'h44, 0, 0, acc);
    chk("fill_5th_held", acc, 0);
    for (int k = 0; k < 50 && !acc; k++) step(1, 4'h4, 8'h44, 1, 1, acc);
    chk("fill_5th_accepted", acc, 1);
    for (int k = 0; k < 50 && q.size() > 0; k++) step(0, 0, 0, 1, 1, acc);
    step(0, 0, 0, 1, 1, acc);
    chk("fill_cnt", sent_cnt, 8'(base + 5));
    // Concurrent push/pop at occupancy 2, pointers wrapping
    step(1, 4'h0, 8'h10, 0, 0, acc);
    step(1, 4'h1, 8'h11, 0, 0, acc);
    n = 2;
    for (int k = 0; k < 100 && n < 16; k++) begin
      step(1, 4'(n), 8'h10 + 8'(n), 1, 1, acc);
      if (acc) n++;
      if (k > 0 && n < 16) chk("occupancy", q.size(), 2);
    end
    for (int k = 0; k < 50 && q.size() > 0; k++) step(0, 0, 0, 1, 1, acc);
    // Counter wrap over 257 retirements
    base = mcnt;
    for (int k = 0; k < 2000 && mcnt - base < 257; k++)
      step(mcnt - base + q.size() < 257, 4'($urandom), 8'($urandom), 1, 1, acc);
    for (int k = 0; k < 20 && q.size() > 0; k++) step(0, 0, 0, 1, 1, acc);
    step(0, 0, 0, 0, 0, acc);
    chk("wrap_cnt", sent_cnt, 8'(base + 257));
    // Reset mid-transfer with three words queued and A half sent
    for (int i = 0; i < 3; i++) step(1, 4'(i + 7), 8'hB0 + 8'(i), 0, 0, acc);
    step(0, 0, 0, 1, 0, acc);
    step(0, 0, 0, 0, 0, acc);
    #2 _RESET = 0;
    #1;
    chk("mid_rst_a_valid", a_valid, 0);
    chk("mid_rst_b_valid", b_valid, 0);
    chk("mid_rst_empty", empty, 1);
    chk("mid_rst_in_ready", in_ready, 0);
    chk("mid_rst_cnt", sent_cnt, 0);
    q.delete(); mad = 0; mbd = 0; mcnt = 0;
    @(posedge CLK);
    #2 _RESET = 1;
    @(negedge CLK);
    step(1, 4'hA, 8'h55, 0, 0, acc);
    chk("post_rst_a_valid", a_valid, 1);
    chk("post_rst_b_valid", b_valid, 1);
    chk("post_rst_a_data", a_data, 4'hA);
    step(0, 0, 0, 1, 1, acc);
    step(0, 0, 0, 0, 0, acc);
    // Random traffic against the model
    for (int k = 0; k < 1500; k++)
      step($urandom_range(0, 2) != 0, 4'($urandom), 8'($urandom),
           $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, acc);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/ini_injector.md
Name: ini_injector

Overview:
- Clocked RTL stage directly upstream of the Ini block in the NoC. It buffers {address, data} words from the local PE and issues each word as two independent transfers: the 4-bit address on the A channel and the 8-bit data on the B channel.
- Ini may accept A and B in either order or in the same cycle. A word is retired only after both halves are accepted.
- In cosim, the A/B valid/ready pairs connect to the A_RTL/B_RTL channels through the existing cosim wrapper.

Parameters:
- DEPTH, 4, FIFO word count; power of 2, minimum 2.
- ADDR_W, 4, address width; matches the Ini A channel.
- DATA_W, 8, payload width; matches the Ini B channel.
- CNT_W, 8, width of the retired-word counter.

Ports:
- CLK  in  1  single clock, rising edge.
- _RESET  in  1  asynchronous active-low reset.
- in_valid  in  1  PE offers a word.
- in_ready  out  1  FIFO can accept a word.
- in_addr  in  ADDR_W  destination address of the offered word.
- in_data  in  DATA_W  payload of the offered word.
- a_valid  out  1  A-channel transfer pending.
- a_ready  in  1  Ini accepts A.
- a_data  out  ADDR_W  head-word address.
- b_valid  out  1  B-channel transfer pending.
- b_ready  in  1  Ini accepts B.
- b_data  out  DATA_W  head-word payload.
- sent_cnt  out  CNT_W  number of words fully retired, modulo 2^CNT_W.
- empty  out  1  FIFO holds no word.
- full  out  1  FIFO holds DEPTH words.

Behaviour:
- Reset (asynchronous, _RESET=0):
  - Clears write pointer, read pointer, occupancy, a_done, b_done and sent_cnt.
  - Outputs during reset: in_ready=0, a_valid=0, b_valid=0, empty=1, full=0, sent_cnt=0; a_data/b_data are don't-care.
  - in_ready rises in the first cycle after _RESET deasserts.
  - Asserting reset mid-operation discards all buffered words and partial-send state immediately, without waiting for a clock edge.
- Enqueue:
  - in_ready = !full && reset released.
  - A word is written on a rising edge where in_valid && in_ready.
  - There is no bypass: a word written at edge n drives a_valid/b_valid from edge n onward, i.e. one-cycle latency, visible in the cycle after acceptance.
  - When full, in_ready=0, even if a pop happens in the same cycle.
- Issue:
  - a_valid = !empty && !a_done; b_valid = !empty && !b_done.
  - a_data and b_data always reflect the FIFO head.
  - valid, once high, stays high with stable data until the matching ready is sampled high. It never drops without a handshake, except on reset.
- Per-word state machine on the flags {a_done, b_done}. States: IDLE(00), A_SENT(10), B_SENT(01).
  - IDLE: A handshake only -> A_SENT; B handshake only -> B_SENT; both in the same edge -> pop and stay IDLE.
  - A_SENT: B handshake -> pop, IDLE.
  - B_SENT: A handshake -> pop, IDLE.
  - State 11 is never stored; completion always pops.
- Pop:
  - Advances the read pointer and increments sent_cnt, which wraps from 2^CNT_W-1 to 0.
  - A new head is presented in the cycle after the pop, with both valids high if the FIFO is non-empty.
- Simultaneous push and pop in one edge: occupancy unchanged; both pointers advance modulo DEPTH.
- Pointers: log2(DEPTH)+1 bits with a wrap bit.
  - empty = (wptr == rptr).
  - full = (addresses equal && wrap bits differ).
- Ready inputs sampled while the matching valid is low are ignored.

Decomposition:
- Shared package noc_pkg holds ADDR_W, DATA_W defaults and the typedef ini_word_t = struct {addr, data}.
- One natural sub-module, ini_fifo: parameterised synchronous FIFO with async active-low reset. It exposes push, pop, head, empty and full.
- ini_injector holds the A/B done-flag FSM and the counter.

Test Plan:
1. Reset then single word: push {addr=4'h5, data=8'hA3} with a_ready=b_ready=1 held -> a_valid=b_valid=1 one cycle after push, a_data=5, b_data=A3; pops the following edge; sent_cnt=1, empty=1.
2. Split order: push {3, 8'h7E}; b_ready=1 at cycle 2, a_ready=1 at cycle 5 -> b_valid drops after cycle 2, a_valid stays high with a_data=3 through cycle 5; pop at cycle 5; sent_cnt=1.
3. Fill: push 5 words with a_ready=b_ready=0 -> in_ready=0 and full=1 after 4 words; 5th word held off; release readies -> words drain in order 0..3, then the 5th is accepted; sent_cnt=5.
4. Concurrent push and pop at occupancy 2 with both readies high -> occupancy stays 2; pointer wrap past DEPTH preserves order (sequence 0x10..0x1F retired in order).
5. Counter wrap: retire 257 words -> sent_cnt=1.
6. Reset mid-transfer: 3 words queued and A_SENT state, drop _RESET between edges -> a_valid=b_valid=0 and empty=1 immediately; after release the first new word issues both A and B fresh.
